// File: rtl/axis_cabs_rr.sv
// Round-robin multi-tag |I,Q| engine: credit-gated input arbiter, fixed 4-stage
// magnitude pipe and an output FIFO that returns each result to its source tag.
module axis_cabs_rr #(
   parameter int  NUM_TAGS   = 20,
   parameter int  NUM_LANES  = 4,
   parameter int  WORD_WIDTH = 32,
   parameter int  FIFO_DEPTH = 16,
   localparam int CW = $clog2(NUM_TAGS),
   localparam int DW = NUM_LANES*2*WORD_WIDTH,
   localparam int AW = NUM_LANES*2*WORD_WIDTH,
   localparam int LW = $clog2(FIFO_DEPTH)+1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             cfg_mode,
   input  logic [NUM_TAGS-1:0]    s_axis_tvalid,
   output logic [NUM_TAGS-1:0]    s_axis_tready,
   input  logic [NUM_TAGS*DW-1:0] s_axis_tdata,
   output logic [NUM_TAGS-1:0]    m_axis_tvalid,
   input  logic [NUM_TAGS-1:0]    m_axis_tready,
   output logic [DW-1:0]          m_axis_tdata,
   output logic [AW-1:0]          m_axis_tdata_abs,
   output logic [CW-1:0]          m_axis_tchan,
   output logic [LW-1:0]          fifo_level
);

   localparam int W  = WORD_WIDTH;
   localparam int FA = $clog2(FIFO_DEPTH);

   logic [CW-1:0] rr_ptr;
   logic [CW-1:0] grant;
   logic          grant_vld;
   logic [LW-1:0] credits;
   logic          accept;
   logic          pop;
   int            idx;

   always_comb begin
      idx       = 0;
      grant     = '0;
      grant_vld = 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_TAGS) idx = idx - NUM_TAGS;
         if (!grant_vld && s_axis_tvalid[idx]) begin
            grant_vld = 1'b1;
            grant     = CW'(idx);
         end
      end
   end

   always_comb begin
      s_axis_tready = '0;
      if (grant_vld && credits != '0 && !rst) s_axis_tready[grant] = 1'b1;
   end

   assign accept = |(s_axis_tvalid & s_axis_tready);

   // each credit is one FIFO slot reserved for a beat already in the pipe or queued
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         credits <= LW'(FIFO_DEPTH);
      end else begin
         if (accept) rr_ptr <= (grant == CW'(NUM_TAGS-1)) ? '0 : grant + CW'(1);
         case ({accept, pop})
            2'b10:   credits <= credits - LW'(1);
            2'b01:   credits <= credits + LW'(1);
            default: credits <= credits;
         endcase
      end
   end

   function automatic logic [W:0] mag(input logic [W-1:0] x);
      logic [W:0] xe;
      xe = {x[W-1], x};
      return x[W-1] ? (~xe + (W+1)'(1)) : xe;
   endfunction

   logic          s1_valid, s2_valid, s3_valid, s4_valid;
   logic [CW-1:0] s1_tag, s2_tag, s3_tag, s4_tag;
   logic [1:0]    s1_mode, s2_mode;
   logic [DW-1:0] s1_data, s2_data, s3_data, s4_data;
   logic [W:0]    s2_abs_i [NUM_LANES];
   logic [W:0]    s2_abs_q [NUM_LANES];
   logic [AW-1:0] s3_res, s4_res, s3_res_d;

   logic [2*W-1:0] sq_i, sq_q;
   logic [W:0]     ai, aq, mx, mn;

   always_comb begin
      s3_res_d = '0;
      sq_i     = '0;
      sq_q     = '0;
      ai       = '0;
      aq       = '0;
      mx       = '0;
      mn       = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         ai   = s2_abs_i[k];
         aq   = s2_abs_q[k];
         sq_i = (2*W)'(ai) * (2*W)'(ai);
         sq_q = (2*W)'(aq) * (2*W)'(aq);
         mx   = (ai > aq) ? ai : aq;
         mn   = (ai > aq) ? aq : ai;
         case (s2_mode)
            2'd1:    s3_res_d[k*2*W +: 2*W] = (2*W)'(mx) + (2*W)'(mn >> 1);
            2'd2:    s3_res_d[k*2*W +: 2*W] = (2*W)'(ai) + (2*W)'(aq);
            default: s3_res_d[k*2*W +: 2*W] = sq_i + sq_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         s4_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
         s4_valid <= s3_valid;
      end
   end

   // payload needs no reset: it is qualified by the stage valids
   always_ff @(posedge clk) begin
      s1_tag  <= grant;
      s1_mode <= cfg_mode;
      s1_data <= s_axis_tdata[int'(grant)*DW +: DW];
      s2_tag  <= s1_tag;
      s2_mode <= s1_mode;
      s2_data <= s1_data;
      for (int k = 0; k < NUM_LANES; k++) begin
         s2_abs_i[k] <= mag(s1_data[k*2*W +: W]);
         s2_abs_q[k] <= mag(s1_data[k*2*W+W +: W]);
      end
      s3_tag  <= s2_tag;
      s3_data <= s2_data;
      s3_res  <= s3_res_d;
      s4_tag  <= s3_tag;
      s4_data <= s3_data;
      s4_res  <= s3_res;
   end

   logic [CW-1:0] mem_tag  [FIFO_DEPTH];
   logic [DW-1:0] mem_data [FIFO_DEPTH];
   logic [AW-1:0] mem_abs  [FIFO_DEPTH];
   logic [FA-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] count;
   logic          not_empty;
   logic [CW-1:0] head_tag;

   assign not_empty = (count != '0);
   assign head_tag  = mem_tag[rd_ptr];
   assign pop       = not_empty && m_axis_tready[head_tag];

   always_ff @(posedge clk) begin
      if (s4_valid) begin
         mem_tag[wr_ptr]  <= s4_tag;
         mem_data[wr_ptr] <= s4_data;
         mem_abs[wr_ptr]  <= s4_res;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (s4_valid) wr_ptr <= wr_ptr + FA'(1);
         if (pop)      rd_ptr <= rd_ptr + FA'(1);
         case ({s4_valid, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      m_axis_tvalid = '0;
      if (not_empty) m_axis_tvalid[head_tag] = 1'b1;
   end

   assign m_axis_tchan     = not_empty ? head_tag : '0;
   assign m_axis_tdata     = not_empty ? mem_data[rd_ptr] : '0;
   assign m_axis_tdata_abs = not_empty ? mem_abs[rd_ptr] : '0;
   assign fifo_level       = count;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(s4_valid && count == LW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_axis_cabs_rr.sv
// Bench for axis_cabs_rr: cycle model of arbiter/credits/FIFO with a scoreboard
// queue, a magnitude vector table, and hand sequences for reset and backpressure.
module tb_axis_cabs_rr;
   localparam int NT = 20;
   localparam int NL = 4;
   localparam int W  = 32;
   localparam int FD = 16;
   localparam int DW = NL*2*W;
   localparam int CW = 5;
   localparam int LW = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       cfg_mode;
   logic [NT-1:0]    s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready;
   logic [NT*DW-1:0] s_axis_tdata;
   logic [DW-1:0]    m_axis_tdata, m_axis_tdata_abs;
   logic [CW-1:0]    m_axis_tchan;
   logic [LW-1:0]    fifo_level;

   axis_cabs_rr dut (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tdata_abs(m_axis_tdata_abs), .m_axis_tchan(m_axis_tchan), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         tag;
      logic [255:0] data;
      logic [255:0] abs;
      int         acyc;
   } sb_t;

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] i;
      logic [31:0] q;
      logic [63:0] exp;
   } vec_t;

   sb_t          sbq[$];
   int           acc_log[$];
   vec_t         vt[12];
   logic [255:0] src_data [NT];
   int           src_cnt [NT];
   int           total = 0, bad = 0, cyc = 0;
   int           mdl_ptr = 0, acc_tag = 0, dut_acc_n = 0, dut_first = 0, dut_last = 0;
   bit           acc_flag = 0, pop_seen = 0, toggle_mode = 0, rand_ready = 0;
   logic [255:0] last_abs;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 7))
         0:       return 32'h8000_0000;
         1:       return 32'h7fff_ffff;
         default: return $urandom();
      endcase
   endfunction

   function automatic logic [255:0] rand_beat();
      logic [255:0] b;
      for (int i = 0; i < 8; i++) b[i*32 +: 32] = rand_word();
      return b;
   endfunction

   function automatic logic [255:0] model_abs(input logic [255:0] d, input logic [1:0] m);
      logic [255:0] r;
      longint       li, lq;
      logic [63:0]  a_i, a_q, mx, mn;
      r = '0;
      for (int k = 0; k < NL; k++) begin
         li  = longint'($signed(d[k*64 +: 32]));
         lq  = longint'($signed(d[k*64+32 +: 32]));
         a_i = (li < 0) ? -li : li;
         a_q = (lq < 0) ? -lq : lq;
         mx  = (a_i > a_q) ? a_i : a_q;
         mn  = (a_i > a_q) ? a_q : a_i;
         case (m)
            2'd1:    r[k*64 +: 64] = mx + (mn >> 1);
            2'd2:    r[k*64 +: 64] = a_i + a_q;
            default: r[k*64 +: 64] = a_i*a_i + a_q*a_q;
         endcase
      end
      return r;
   endfunction

   task automatic apply_inputs();
      for (int t = 0; t < NT; t++) begin
         s_axis_tvalid[t]          = (src_cnt[t] > 0);
         s_axis_tdata[t*DW +: DW]  = src_data[t];
      end
   endtask

   // Model view of one cycle, sampled at the falling edge.
   task automatic observe();
      logic [NT-1:0] exp_rdy, oh, dut_acc;
      int            lvl, g;
      bit            found;
      sb_t           e;
      acc_flag = 0;
      if (rst) return;
      dut_acc = s_axis_tvalid & s_axis_tready;
      if (dut_acc != '0) begin
         for (int i = 0; i < NT; i++) if (dut_acc[i]) acc_log.push_back(i);
         dut_acc_n++;
         if (dut_acc_n == 1) dut_first = cyc;
         dut_last = cyc;
      end
      exp_rdy = '0;
      found   = 0;
      g       = 0;
      if (sbq.size() < FD) begin
         for (int i = 0; i < NT; i++) begin
            if (!found && src_cnt[(mdl_ptr+i)%NT] > 0) begin
               found = 1;
               g     = (mdl_ptr+i)%NT;
               exp_rdy[g] = 1'b1;
            end
         end
      end
      chk("tready", 256'(s_axis_tready), 256'(exp_rdy));
      lvl = 0;
      foreach (sbq[i]) if (cyc >= sbq[i].acyc + 5) lvl++;
      chk("level", 256'(fifo_level), 256'(lvl));
      if (lvl > 0) begin
         oh = '0;
         oh[sbq[0].tag] = 1'b1;
         chk("m_valid", 256'(m_axis_tvalid), 256'(oh));
         chk("tchan", 256'(m_axis_tchan), 256'(sbq[0].tag));
         chk("tdata", m_axis_tdata, sbq[0].data);
         chk("abs", m_axis_tdata_abs, sbq[0].abs);
         if (m_axis_tready[sbq[0].tag]) begin
            last_abs = m_axis_tdata_abs;
            pop_seen = 1;
            void'(sbq.pop_front());
         end
      end else begin
         chk("m_valid idle", 256'(m_axis_tvalid), 256'(0));
      end
      if (found) begin
         e.tag  = g;
         e.data = src_data[g];
         e.abs  = model_abs(src_data[g], cfg_mode);
         e.acyc = cyc;
         sbq.push_back(e);
         mdl_ptr  = (g + 1) % NT;
         acc_flag = 1;
         acc_tag  = g;
      end
   endtask

   task automatic step();
      @(negedge clk);
      observe();
      @(posedge clk);
      cyc++;
      #1;
      if (acc_flag) begin
         src_cnt[acc_tag]--;
         src_data[acc_tag] = rand_beat();
      end
      if (toggle_mode) cfg_mode = cfg_mode + 2'd1;
      if (rand_ready) m_axis_tready = NT'($urandom());
      apply_inputs();
   endtask

   task automatic run_until_idle(input int maxc);
      int  n;
      bit  busy;
      n    = 0;
      busy = 1;
      while (busy && n < maxc) begin
         step();
         n++;
         busy = (sbq.size() > 0);
         for (int t = 0; t < NT; t++) if (src_cnt[t] > 0) busy = 1;
      end
      chk("idle timeout", 256'(busy), 256'(0));
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      sbq.delete();
      mdl_ptr = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq3[3];
      int n;
      seq3 = '{2, 5, 19};
      vt[0]  = '{2'd0, 32'd3,         32'hffff_fffc, 64'd25};
      vt[1]  = '{2'd1, 32'd3,         32'hffff_fffc, 64'd5};
      vt[2]  = '{2'd2, 32'd3,         32'hffff_fffc, 64'd7};
      vt[3]  = '{2'd3, 32'd3,         32'hffff_fffc, 64'd25};
      vt[4]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 64'h8000_0000_0000_0000};
      vt[5]  = '{2'd2, 32'h8000_0000, 32'h8000_0000, 64'h1_0000_0000};
      vt[6]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 64'hc000_0000};
      vt[7]  = '{2'd0, 32'h7fff_ffff, 32'h8000_0000, 64'h7fff_ffff_0000_0001};
      vt[8]  = '{2'd2, 32'd0,         32'd0,         64'd0};
      vt[9]  = '{2'd1, 32'hffff_fff9, 32'd2,         64'd8};
      vt[10] = '{2'd2, 32'hffff_ffff, 32'd1,         64'd2};
      vt[11] = '{2'd1, 32'd5,         32'd5,         64'd7};

      cfg_mode      = 2'd0;
      m_axis_tready = '1;
      for (int t = 0; t < NT; t++) begin
         src_cnt[t]  = 1;
         src_data[t] = rand_beat();
      end
      apply_inputs();

      // reset held with every source valid
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst tready", 256'(s_axis_tready), 256'(0));
         chk("rst m_valid", 256'(m_axis_tvalid), 256'(0));
         chk("rst level", 256'(fifo_level), 256'(0));
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("first grant", 256'(s_axis_tready), 256'(1));
      acc_log.delete();
      run_until_idle(200);
      chk("rst order n", 256'(acc_log.size()), 256'(NT));
      for (int i = 0; i < acc_log.size() && i < NT; i++)
         chk($sformatf("rst order %0d", i), 256'(acc_log[i]), 256'(i));

      // round-robin over tags 2, 5, 19
      do_reset(2);
      acc_log.delete();
      dut_acc_n = 0;
      src_cnt[2] = 30; src_cnt[5] = 30; src_cnt[19] = 30;
      apply_inputs();
      run_until_idle(400);
      chk("rr count", 256'(acc_log.size()), 256'(90));
      for (int i = 0; i < acc_log.size() && i < 90; i++)
         chk($sformatf("rr order %0d", i), 256'(acc_log[i]), 256'(seq3[i%3]));
      chk("rr throughput", 256'(dut_last - dut_first), 256'(89));

      // magnitude vectors on tag 0
      for (int v = 0; v < 12; v++) begin
         cfg_mode    = vt[v].mode;
         src_data[0] = {4{vt[v].q, vt[v].i}};
         src_cnt[0]  = 1;
         pop_seen    = 0;
         apply_inputs();
         n = 0;
         while (!pop_seen && n < 20) begin
            step();
            n++;
         end
         chk($sformatf("vec%0d", v), last_abs, pop_seen ? {4{vt[v].exp}} : 256'(0));
      end

      // mode changes every cycle; each beat must use its own sampled mode
      toggle_mode = 1;
      src_cnt[1] = 20; src_cnt[4] = 20;
      apply_inputs();
      run_until_idle(400);
      toggle_mode = 0;
      cfg_mode = 2'd0;

      // full backpressure: exactly FIFO_DEPTH beats accepted
      m_axis_tready = '0;
      dut_acc_n = 0;
      src_cnt[3] = 1000; src_cnt[7] = 1000;
      apply_inputs();
      for (int i = 0; i < 30; i++) step();
      #1;
      chk("bp accepts", 256'(dut_acc_n), 256'(FD));
      chk("bp tready", 256'(s_axis_tready), 256'(0));
      chk("bp level", 256'(fifo_level), 256'(FD));

      // random pops at/near full while sources keep streaming
      rand_ready = 1;
      for (int i = 0; i < 120; i++) step();
      rand_ready = 0;
      m_axis_tready = '1;
      src_cnt[3] = 0; src_cnt[7] = 0;
      apply_inputs();
      run_until_idle(200);

      // reset with 3 beats in the pipe and 7 queued
      m_axis_tready = '0;
      dut_acc_n = 0;
      src_cnt[9] = 10;
      apply_inputs();
      n = 0;
      while (dut_acc_n < 10 && n < 40) begin
         step();
         n++;
      end
      step();
      chk("mid level", 256'(fifo_level), 256'(7));
      rst = 1'b1;
      #1;
      chk("mid rst tready", 256'(s_axis_tready), 256'(0));
      chk("mid rst m_valid", 256'(m_axis_tvalid), 256'(0));
      chk("mid rst level", 256'(fifo_level), 256'(0));
      chk("mid rst tchan", 256'(m_axis_tchan), 256'(0));
      chk("mid rst tdata", m_axis_tdata, 256'(0));
      chk("mid rst abs", m_axis_tdata_abs, 256'(0));
      sbq.delete();
      mdl_ptr = 0;
      for (int t = 0; t < NT; t++) src_cnt[t] = 0;
      apply_inputs();
      @(posedge clk);
      #1;
      chk("mid rst hold level", 256'(fifo_level), 256'(0));
      rst = 1'b0;
      m_axis_tready = '1;
      src_cnt[0] = 6; src_cnt[9] = 6;
      apply_inputs();
      run_until_idle(200);
      for (int i = 0; i < 10; i++) step();
      chk("post rst level", 256'(fifo_level), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
